// File: rtl/channel_pkg.sv
// Shared types and helpers for the executor output channel reader.
package channel_pkg;

   localparam int unsigned MEM_ELEM_W = 12;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chan_state_e;

   // Position increment with an explicit wrap, so depth need not be a power of two.
   function automatic int unsigned next_pos(input int unsigned pos, input int unsigned depth);
      return (pos == depth - 1) ? 0 : pos + 1;
   endfunction

endpackage

// File: rtl/channel_ring.sv
// Circular word store with drop-oldest on overflow and a registered head word.
module channel_ring
   import channel_pkg::*;
#(
   parameter int W = MEM_ELEM_W,
   parameter int NOut = 2000,
   localparam int PosWidth = $clog2(NOut)
) (
   input  logic                clock,
   input  logic                resetN,
   input  logic                clr,
   input  logic                push,
   input  logic                pop,
   input  logic [W-1:0]        wdata,
   output logic [W-1:0]        rdata,
   output logic [PosWidth:0]   count,
   output logic                drop
);

   typedef logic [PosWidth-1:0] pos_t;
   typedef logic [PosWidth:0]   cnt_t;

   logic [W-1:0] mem_q [NOut];
   pos_t         rd_pos_q, rd_pos_d, wr_pos_q, wr_pos_d;
   cnt_t         count_q, count_d;
   logic [W-1:0] rd_data_q, rd_data_d;
   logic         full;

   always_comb begin
      full     = (count_q == cnt_t'(NOut));
      drop     = push && full && !pop;
      rd_pos_d = (pop || drop) ? pos_t'(next_pos(int'(rd_pos_q), NOut)) : rd_pos_q;
      wr_pos_d = push ? pos_t'(next_pos(int'(wr_pos_q), NOut)) : wr_pos_q;
      count_d  = count_q;
      if (push && !pop && !full)
         count_d = count_q + cnt_t'(1);
      else if (pop && !push)
         count_d = count_q - cnt_t'(1);
      // The head word is re-registered every change; bypass when the new head is being written now.
      rd_data_d = rd_data_q;
      if (count_d != '0)
         rd_data_d = (push && rd_pos_d == wr_pos_q) ? wdata : mem_q[rd_pos_d];
      if (clr) begin
         rd_pos_d = '0;
         wr_pos_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         rd_pos_q  <= '0;
         wr_pos_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         rd_pos_q  <= rd_pos_d;
         wr_pos_q  <= wr_pos_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push && !clr)
         mem_q[wr_pos_q] <= wdata;
   end

   assign rdata = rd_data_q;
   assign count = count_q;

endmodule

// File: rtl/out_channel_reader.sv
// Reader end of the executor output channel: run/drain FSM around the ring buffer.
module out_channel_reader
   import channel_pkg::*;
#(
   parameter int MemoryElementWidth = MEM_ELEM_W,
   parameter int NOut = 2000,
   localparam int PosWidth = $clog2(NOut)
) (
   input  logic                          clock,
   input  logic                          resetN,
   input  logic                          start,
   input  logic                          outValid,
   input  logic [MemoryElementWidth-1:0] outData,
   input  logic                          finished,
   output logic                          readValid,
   output logic [MemoryElementWidth-1:0] readData,
   input  logic                          readReady,
   output logic [PosWidth:0]             count,
   output logic                          overflow,
   output logic                          drained
);

   chan_state_e state_q, state_d;
   logic        overflow_q, overflow_d;
   logic        drained_q, drained_d;
   logic        push, pop, drop, active;

   assign active    = (state_q == RUN) || (state_q == DRAIN);
   assign readValid = (count != '0);
   assign push      = !start && (state_q == RUN) && outValid;
   assign pop       = !start && active && readValid && readReady;

   channel_ring #(.W(MemoryElementWidth), .NOut(NOut)) u_ring (
      .clock (clock),
      .resetN(resetN),
      .clr   (start),
      .push  (push),
      .pop   (pop),
      .wdata (outData),
      .rdata (readData),
      .count (count),
      .drop  (drop)
   );

   always_comb begin
      state_d    = state_q;
      overflow_d = overflow_q;
      drained_d  = drained_q;
      if (start) begin
         state_d    = RUN;
         overflow_d = 1'b0;
         drained_d  = 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               overflow_d = overflow_q || drop;
               if (finished)
                  state_d = DRAIN;
            end
            DRAIN: begin
               if (count == '0) begin
                  state_d   = DONE;
                  drained_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q    <= IDLE;
         overflow_q <= 1'b0;
         drained_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         overflow_q <= overflow_d;
         drained_q  <= drained_d;
      end
   end

   assign overflow = overflow_q;
   assign drained  = drained_q;

endmodule
